cmd_uart_responder: RTL
=======================

// Module: cmd_uart_responder
// PURPOSE
//  Knight-side end of the RemoteComm link: deserializes 8N1 UART bytes on RX, pairs them
//  (high byte first, then low byte) into a 16-bit command for cmd_proc, and serializes the
//  8-bit response (e.g. 0xA5 ack) back on TX. Sits between the RX/TX pins and cmd_proc.
// PARAMETERS
//  BAUD_DIV      2604       clk cycles per bit (19200 baud @ 50 MHz); must be >= 16
//  TIMEOUT_CLKS  2_000_000  clocks allowed between high and low byte (CMD_TIMEOUT_EN only)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   synchronous reset, active-high
//  RX           in   1   serial in, idle high, asynchronous to clk
//  TX           out  1   serial out, idle high
//  cmd          out  16  assembled command {high_byte, low_byte}
//  cmd_rdy      out  1   command valid, level, held until cleared
//  clr_cmd_rdy  in   1   consumer acknowledges cmd
//  resp         in   8   response byte, sampled when trmt is accepted
//  trmt         in   1   one-cycle pulse: send resp
//  tx_done      out  1   response frame fully sent (level)
//  frame_err    out  1   one-cycle pulse: received stop bit was 0
// BEHAVIOUR
//  Reset: TX=1, cmd=0, cmd_rdy=0, tx_done=0, frame_err=0, both FSMs idle, byte pairing -> HIGH.
//  RX sync: RX passes two flops (reset to 1) before use; edge detect on synced value.
//  RX FSM IDLE->START on synced falling edge; START waits BAUD_DIV/2, re-samples: 1 -> IDLE
//   (glitch), 0 -> DATA. DATA samples 8 bits at BAUD_DIV spacing, LSB first. STOP samples
//   after BAUD_DIV: 1 -> byte valid pulse, 0 -> frame_err pulse, byte dropped; both -> IDLE.
//  Pairing FSM HIGH/LOW: valid byte in HIGH -> latch cmd[15:8], clear cmd_rdy, -> LOW.
//   Valid byte in LOW -> cmd[7:0] loaded, cmd_rdy=1 the cycle after stop sample, -> HIGH.
//   frame_err does not change pairing state.
//  cmd holds stable while cmd_rdy=1 except a new high byte overwrites cmd[15:8].
//  clr_cmd_rdy clears cmd_rdy next cycle; if clr and a set occur same cycle, set wins.
//  TX FSM IDLE/START/DATA/STOP, one bit per BAUD_DIV clocks, LSB first, 10 bits total.
//   trmt in IDLE: latch resp, clear tx_done, start bit begins next cycle.
//   trmt while busy is ignored (no queue, tx_done unaffected).
//   tx_done set at end of stop bit (10*BAUD_DIV clocks after start), held until next trmt.
//  RX and TX are fully independent; full-duplex traffic allowed.
//  Baud counters are clog2(BAUD_DIV)-bit, reload on each bit; no wrap beyond BAUD_DIV-1.
//  rst mid-frame: both FSMs abort, TX returns high same edge, partial bytes discarded.
// CONFIGURATION
//  CMD_TIMEOUT_EN defined: counter runs in pairing state LOW; reaching TIMEOUT_CLKS with
//   no low byte -> discard high byte, return to HIGH, cmd/cmd_rdy untouched. Counter
//   clears on each valid byte.
//  CMD_TIMEOUT_EN undefined: no counter, LOW waits indefinitely; TIMEOUT_CLKS unused.
// TESTING
//  RX bytes 0x70 then 0x00 -> cmd=16'h7000, cmd_rdy=1 exactly once; clr_cmd_rdy -> 0.
//  trmt with resp=8'hA5 -> TX: 0,1,0,1,0,0,1,0,1,1 each BAUD_DIV clks; tx_done after 10 bits.
//  Byte 0x12 with stop bit 0 -> frame_err pulse, pairing stays HIGH; then 0x34,0x56 -> 16'h3456.
//  2-cycle low glitch on RX -> no byte, no frame_err, FSM back to IDLE.
//  clr_cmd_rdy asserted in same cycle as cmd_rdy set -> cmd_rdy=1 afterward.
//  CMD_TIMEOUT_EN: 0xAB, idle > TIMEOUT_CLKS, then 0x10,0x22 -> cmd=16'h1022.
//  rst during TX data bit 4 -> TX=1 next edge, tx_done=0; next trmt sends full frame.

Source files
------------

// File: rtl/cmd_uart_responder.sv
// UART command responder: receives 8N1 byte pairs into a 16-bit command and serializes 8-bit responses.
// Optional feature: define CMD_TIMEOUT_EN to abandon a high byte when no low byte follows in time.
module cmd_uart_responder #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_CLKS = 2_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        frame_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  if (BAUD_DIV < 16 || TIMEOUT_CLKS < 1) begin : g_param_check
    $error("cmd_uart_responder: BAUD_DIV must be >= 16 and TIMEOUT_CLKS >= 1");
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic       {PAIR_HIGH, PAIR_LOW} pair_state_t;

  rx_state_t   rx_state, rx_next;
  tx_state_t   tx_state, tx_next;
  pair_state_t pair_state, pair_next;

  logic          rx_s1, rx_s2, rx_prev, rx_fall;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_tick, byte_valid, frame_bad;

  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_tick;

  logic          timeout;

  // RX is asynchronous: two sync flops (idle-high reset) plus one more for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev & ~rx_s2;
  assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_LAST) : (rx_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next    = rx_state;
    byte_valid = 1'b0;
    frame_bad  = 1'b0;
    unique case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_tick) begin
          rx_next    = RX_IDLE;
          byte_valid = rx_s2;
          frame_bad  = ~rx_s2;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
      else                                rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) rx_bit <= '0;
      if (rx_state == RX_DATA && rx_tick) begin
        rx_shift <= {rx_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pair_state <= PAIR_HIGH;
    else     pair_state <= pair_next;
  end

  always_comb begin
    pair_next = pair_state;
    unique case (pair_state)
      PAIR_HIGH: if (byte_valid) pair_next = PAIR_LOW;
      PAIR_LOW:  if (byte_valid || timeout) pair_next = PAIR_HIGH;
      default:   pair_next = PAIR_HIGH;
    endcase
  end

  // A low byte setting cmd_rdy takes priority over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= '0;
      cmd_rdy <= 1'b0;
    end else if (byte_valid && pair_state == PAIR_HIGH) begin
      cmd[15:8] <= rx_shift;
      cmd_rdy   <= 1'b0;
    end else if (byte_valid && pair_state == PAIR_LOW) begin
      cmd[7:0] <= rx_shift;
      cmd_rdy  <= 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_rdy <= 1'b0;
    end
  end

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_cnt;

  assign timeout = (pair_state == PAIR_LOW) && !byte_valid && (to_cnt == TW'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk) begin
    if (rst || pair_state != PAIR_LOW || byte_valid || timeout) to_cnt <= '0;
    else                                                         to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  assign tx_tick = (tx_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      TX_IDLE:  if (trmt) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // TX is registered so the pin never glitches; each bit is loaded on the edge that ends the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      TX       <= 1'b1;
      tx_done  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
      else                                tx_cnt <= tx_cnt + 1'b1;
      unique case (tx_state)
        TX_IDLE: begin
          if (trmt) begin
            tx_shift <= resp;
            tx_done  <= 1'b0;
            tx_bit   <= '0;
            TX       <= 1'b0;
          end
        end
        TX_START: if (tx_tick) TX <= tx_shift[0];
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_bit == 3'd7) begin
              TX <= 1'b1;
            end else begin
              TX       <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 3'd1;
            end
          end
        end
        TX_STOP: if (tx_tick) tx_done <= 1'b1;
        default: TX <= 1'b1;
      endcase
    end
  end

endmodule
